// File: rtl/iterative_shifter_pkg.sv
// Shared encodings for the iterative shifter: op codes, FSM states, default width.
package shift_pkg;
  localparam int DEFAULT_WIDTH = 16;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASL = 2'b10;
  localparam logic [1:0] OP_ASR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/iterative_shifter_if.sv
// Start/done bus of the iterative shifter. With ITERATIVE_SHIFTER_OVF_EN an ovf flag rides with Y.
interface iterative_shifter_if
  import shift_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  // Handshake: start is taken on a rising edge only while ready=1 (IDLE or DONE);
  // A/shamt/op matter only in that cycle. done pulses one cycle with a fresh Y.
  logic               start;
  logic [WIDTH-1:0]   A;
  logic [SHAMT_W-1:0] shamt;
  logic [1:0]         op;
  logic               ready;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   Y;
`ifdef ITERATIVE_SHIFTER_OVF_EN
  logic               ovf;

  modport master (output start, A, shamt, op, input ready, busy, done, Y, ovf);
  modport slave  (input start, A, shamt, op, output ready, busy, done, Y, ovf);
`else
  modport master (output start, A, shamt, op, input ready, busy, done, Y);
  modport slave  (input start, A, shamt, op, output ready, busy, done, Y);
`endif
endinterface

// File: rtl/iterative_shifter_step.sv
// Combinational single-bit shift of the work register, selected by op.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       i_op,
  output logic [WIDTH-1:0] o_data
);
  always_comb begin
    o_data = i_data;
    case (i_op)
      OP_LSL, OP_ASL: o_data = {i_data[WIDTH-2:0], 1'b0};
      OP_LSR:         o_data = {1'b0, i_data[WIDTH-1:1]};
      OP_ASR:         o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
    endcase
  end
endmodule

// File: rtl/iterative_shifter.sv
// Multi-bit shifter applying one single-bit step per clock until shamt is exhausted.
// Optional overflow flag for arithmetic-left: define ITERATIVE_SHIFTER_OVF_EN.
module iterative_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  iterative_shifter_if.slave  bus,
  output state_t              o_dbg_state
);
  localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_cnt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   w_step_data;
  logic               w_accept;
  logic               w_step;
  logic               w_load_y;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_data (r_work),
    .i_op   (r_op),
    .o_data (w_step_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_load_y     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == '0) begin
          w_load_y     = 1'b1;
          w_next_state = ST_DONE;
        end else begin
          w_step = 1'b1;
        end
      end
      ST_DONE: begin
        // A waiting start is taken straight away so results can stream back-to-back.
        if (bus.start) begin
          w_accept     = 1'b1;
          w_next_state = ST_SHIFT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_op   <= OP_LSL;
      r_y    <= '0;
    end else begin
      if (w_accept) begin
        r_work <= bus.A;
        r_cnt  <= bus.shamt;
        r_op   <= bus.op;
      end else if (w_step) begin
        r_work <= w_step_data;
        r_cnt  <= r_cnt - CNT_ONE;
      end
      if (w_load_y) r_y <= r_work;
    end
  end

`ifdef ITERATIVE_SHIFTER_OVF_EN
  logic r_ovf;

  // Sticky: any arithmetic-left step that flips the sign bit loses information.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if (w_step && (r_op == OP_ASL) && (r_work[WIDTH-1] != r_work[WIDTH-2])) begin
      r_ovf <= 1'b1;
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.ready   = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign bus.busy    = (r_state == ST_SHIFT);
  assign bus.done    = (r_state == ST_DONE);
  assign bus.Y       = r_y;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter: directed table, hand sequences, random ops vs model.
module tb_iterative_shifter;
  import shift_pkg::*;

  localparam int W  = 16;
  localparam int SW = 4;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     checks;
  int     errors;

  logic [W-1:0] exp_q[$];
  logic         exp_ovf_q[$];

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [SW-1:0] s;
    logic [W-1:0]  y;
    logic          ovf;
  } vec_t;

  vec_t vecs[7];

  iterative_shifter_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

  iterative_shifter #(.WIDTH(W), .SHAMT_W(SW)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model: whole-operand arithmetic, independent of stepping.
  function automatic logic [W-1:0] model_y(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [SW-1:0] s);
    logic signed [W-1:0] sa;
    sa = a;
    case (op)
      OP_LSR:  return a >> s;
      OP_ASR:  return sa >>> s;
      default: return a << s;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [1:0] op, input logic [W-1:0] a,
                                     input logic [SW-1:0] s);
    logic signed [W-1:0] sl;
    logic        [W-1:0] back;
    sl   = a << s;
    back = sl >>> s;
    return (op == OP_ASL) && (back != a);
  endfunction

  // Drives one op starting at a negedge with ready=1; returns at the done negedge.
  // glitch_at >= 1 pulses start (with A=FFFF) for one cycle while the op is shifting.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [SW-1:0] s,
                        input int glitch_at);
    int           lat;
    logic [W-1:0] ey;
    logic         eo;
    check("ready_before_start", bus.ready, 1'b1);
    bus.start = 1'b1;
    bus.A     = a;
    bus.shamt = s;
    bus.op    = op;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = W'($urandom);
    bus.shamt = SW'($urandom);
    bus.op    = 2'($urandom);
    check("busy_after_accept", bus.busy, 1'b1);
    lat = 0;
    while (!bus.done && lat < 40) begin
      bus.start = (lat + 1 == glitch_at);
      if (bus.start) bus.A = 16'hFFFF;
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
    check("done_seen", bus.done, 1'b1);
    check("latency", 32'(lat), 32'(s) + 32'd1);
    ey = exp_q.pop_front();
    eo = exp_ovf_q.pop_front();
    check("y", bus.Y, ey);
    check("ready_at_done", bus.ready, 1'b1);
    check("busy_at_done", bus.busy, 1'b0);
`ifdef ITERATIVE_SHIFTER_OVF_EN
    check("ovf", bus.ovf, eo);
`else
    if (eo !== 1'b0 && eo !== 1'b1) $display("note: unknown ovf expectation");
`endif
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.shamt = '0;
    bus.op    = OP_LSL;

    vecs[0] = '{OP_LSL, 16'h0001, 4'd4,  16'h0010, 1'b0};
    vecs[1] = '{OP_ASR, 16'h8000, 4'd15, 16'hFFFF, 1'b0};
    vecs[2] = '{OP_LSR, 16'h8000, 4'd15, 16'h0001, 1'b0};
    vecs[3] = '{OP_ASL, 16'h1234, 4'd0,  16'h1234, 1'b0};
    vecs[4] = '{OP_ASL, 16'h4000, 4'd1,  16'h8000, 1'b1};
    vecs[5] = '{OP_ASL, 16'hC000, 4'd1,  16'h8000, 1'b0};
    vecs[6] = '{OP_ASR, 16'h7000, 4'd3,  16'h0E00, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_y", bus.Y, 16'h0000);
    check("rst_done", bus.done, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ready", bus.ready, 1'b1);
    check("rst_state", dbg_state, ST_IDLE);
`ifdef ITERATIVE_SHIFTER_OVF_EN
    check("rst_ovf", bus.ovf, 1'b0);
`endif

    // Directed table, issued back-to-back
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(vecs[i].y);
      exp_ovf_q.push_back(vecs[i].ovf);
      run_op(vecs[i].op, vecs[i].a, vecs[i].s, -1);
    end
    @(negedge clk);
    check("done_one_cycle", bus.done, 1'b0);
    check("idle_after_done", dbg_state, ST_IDLE);

    // Start while shifting is ignored; start held in DONE is taken back-to-back
    exp_q.push_back(16'hFF00);
    exp_ovf_q.push_back(1'b0);
    run_op(OP_LSL, 16'h00FF, 4'd8, 3);
    exp_q.push_back(16'h00F0);
    exp_ovf_q.push_back(1'b0);
    run_op(OP_LSR, 16'h0F00, 4'd4, -1);
    @(negedge clk);

    // Reset mid-operation aborts without a done pulse
    bus.start = 1'b1;
    bus.A     = 16'hF000;
    bus.shamt = 4'd10;
    bus.op    = OP_LSR;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("no_done_pre_abort", bus.done, 1'b0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_done", bus.done, 1'b0);
    check("abort_y", bus.Y, 16'h0000);
    check("abort_ready", bus.ready, 1'b1);
    check("abort_state", dbg_state, ST_IDLE);
    @(negedge clk);
    check("abort_no_late_done", bus.done, 1'b0);
    exp_q.push_back(16'h0001);
    exp_ovf_q.push_back(1'b0);
    run_op(OP_LSR, 16'h0100, 4'd8, -1);

    // Random operations against the model, with random idle gaps
    for (int i = 0; i < 40; i++) begin
      logic [1:0]    rop;
      logic [W-1:0]  ra;
      logic [SW-1:0] rs;
      rop = 2'($urandom_range(0, 3));
      ra  = W'($urandom);
      rs  = SW'($urandom_range(0, W - 1));
      exp_q.push_back(model_y(rop, ra, rs));
      exp_ovf_q.push_back(model_ovf(rop, ra, rs));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(rop, ra, rs, (i % 4 == 0) ? 2 : -1);
    end
    @(negedge clk);
    check("final_done_low", bus.done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iterative_shifter.md
Name: iterative_shifter

Overview:
- Multi-bit shifter for the lab1 ALU datapath.
- Applies a single-bit shift (logical/arithmetic, left/right) once per clock until the requested shift amount is reached.
- Sits downstream of the single-bit shift stages; the ALU result mux consumes its output.
- Start/done handshake; one operation in flight at a time.

Parameters:
- WIDTH, 16, data width in bits.
- SHAMT_W, 4, shift-amount width; must equal $clog2(WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when ready=1.
- A  in  WIDTH  operand, captured when start is accepted.
- shamt  in  SHAMT_W  shift amount 0..WIDTH-1, captured when start is accepted.
- op  in  2  operation: 00 logical left, 01 logical right, 10 arithmetic left, 11 arithmetic right; captured when start is accepted.
- ready  out  1  high in IDLE or DONE; start is accepted this cycle.
- busy  out  1  high in SHIFT.
- done  out  1  one-cycle pulse; Y is valid and new.
- Y  out  WIDTH  result register; holds its value until the next completion.

Behaviour:
- Reset: state=IDLE, Y=0, done=0, busy=0, ready=1; work register and counter cleared.
- Reset asserted mid-operation aborts the operation; Y returns to 0; no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1, load work<=A, cnt<=shamt, latch op; go to SHIFT.
- SHIFT: if cnt==0, Y<=work and go to DONE. Otherwise work<=step(work, op), cnt<=cnt-1, stay in SHIFT.
- DONE: done=1 for exactly this cycle. If start=1, load as in IDLE and go to SHIFT (back-to-back). Otherwise go to IDLE.
- Latency: start sampled at edge k gives done high for the cycle after edge k+shamt+1.
  - shamt=0: 1-cycle latency, Y=A.
  - Back-to-back throughput: one result per shamt+2 cycles.
- start while busy=1 is ignored; no queuing, no error flag.
- A, shamt and op are don't-care except in the accept cycle.
- step() definitions:
  - Logical left: insert 0 at bit 0.
  - Logical right: insert 0 at bit WIDTH-1.
  - Arithmetic left: identical to logical left.
  - Arithmetic right: replicate bit WIDTH-1.
- Results are always WIDTH bits; bits shifted out are discarded.
- done and ready are registered/state-decoded, with no combinational path from start.

Optional Feature:
- Macro: ITERATIVE_SHIFTER_OVF_EN.
- Defined: extra output ovf (1 bit), cleared on reset and on each accept.
  - For op=10 only, set sticky if any step changes bit WIDTH-1 (work[WIDTH-1] != work[WIDTH-2] before the step).
  - Valid with done; holds with Y.
- Undefined: port absent; no ovf logic.

Decomposition:
- Package shift_pkg:
  - op encoding localparams OP_LSL=2'b00, OP_LSR=2'b01, OP_ASL=2'b10, OP_ASR=2'b11.
  - state encoding ST_IDLE, ST_SHIFT, ST_DONE.
  - default WIDTH.
- Sub-module shift_step: combinational single-bit shift of WIDTH bits selected by op; instantiated once.
- FSM, counter, Y register and the optional ovf logic stay in iterative_shifter.

Test Plan:
- op=00, A=0x0001, shamt=4, start at edge k -> done at cycle after edge k+5, Y=0x0010, ready=1 after.
- op=11, A=0x8000, shamt=15 -> Y=0xFFFF. Then op=01, same A/shamt -> Y=0x0001.
- op=10, A=0x1234, shamt=0 -> done 1 cycle after accept, Y=0x1234.
- op=00, A=0x00FF, shamt=8; pulse start with A=0xFFFF mid-SHIFT -> ignored, Y=0xFF00. Start held in DONE with op=01, A=0x0F00, shamt=4 -> accepted back-to-back, Y=0x00F0.
- op=01, A=0xF000, shamt=10; rst=1 for one cycle at 5th cycle -> no done, Y=0, ready=1. Next op=01, A=0x0100, shamt=8 -> Y=0x0001.
- With ITERATIVE_SHIFTER_OVF_EN: op=10, A=0x4000, shamt=1 -> Y=0x8000, ovf=1. A=0xC000, shamt=1 -> Y=0x8000, ovf=0.
